// File: rtl/mem_pkg.sv
// Shared request/response types for the core's decoupled memory protocol.
package mem_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } mem_resp_t;

    localparam logic [3:0] MEM_BE_ALL = 4'hF;

endpackage

// File: rtl/mem_responder_sync_fifo.sv
// Synchronous FIFO with wrapping pointers; occupancy count separates full from empty.
module sync_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  T     din,
    output logic full,
    output logic empty,
    output T     head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    T              mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = do_push ? nxt(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? nxt(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/mem_responder.sv
// Memory endpoint: on-chip word RAM behind a fixed-latency pipeline and an in-order
// response FIFO, with credit-based request flow control.
module mem_responder
    import mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          LATENCY     = 1,
    parameter int          OUTSTANDING = 2,
    parameter string       INIT_FILE   = ""
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      mem_req_valid,
    output logic      mem_req_ready,
    input  mem_req_t  mem_req_data,
    output logic      mem_resp_valid,
    input  logic      mem_resp_ready,
    output mem_resp_t mem_resp_data
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam int          CW   = $clog2(OUTSTANDING + 1);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) << 2;

    logic [31:0]      off;
    logic             in_range;
    logic [AW-1:0]    idx;
    logic             accept, resp_fire;
    logic [CW-1:0]    in_flight_q, in_flight_d;
    logic [LATENCY:1] vld_pipe_q, vld_pipe_d;
    logic             rd_ok_q, rd_ok_d, err_q, err_d;
    logic [31:0]      rd_word_q;
    logic [31:0]      ram_q [DEPTH_WORDS];
    mem_resp_t        s1_resp, pipe_out, fifo_head;
    logic             pipe_vld, fifo_push, fifo_pop, fifo_full, fifo_empty;

    // Subtracting the base first makes addresses below it wrap high and fail the range check.
    assign off      = mem_req_data.addr - BASE_ADDR;
    assign in_range = (off < SPAN);
    assign idx      = off[AW+1:2];

    assign mem_req_ready = (in_flight_q != CW'(OUTSTANDING));
    assign accept        = mem_req_valid && mem_req_ready;
    assign resp_fire     = mem_resp_valid && mem_resp_ready;

    always_comb begin
        in_flight_d = in_flight_q;
        case ({accept, resp_fire})
            2'b10:   in_flight_d = in_flight_q + CW'(1);
            2'b01:   in_flight_d = in_flight_q - CW'(1);
            default: in_flight_d = in_flight_q;
        endcase
        vld_pipe_d    = '0;
        vld_pipe_d[1] = accept;
        for (int k = 2; k <= LATENCY; k++) vld_pipe_d[k] = vld_pipe_q[k-1];
        rd_ok_d = accept ? (in_range && !mem_req_data.we) : rd_ok_q;
        err_d   = accept ? !in_range : err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_flight_q <= '0;
            vld_pipe_q  <= '0;
        end else begin
            in_flight_q <= in_flight_d;
            vld_pipe_q  <= vld_pipe_d;
        end
    end

    always_ff @(posedge clk) begin
        rd_ok_q <= rd_ok_d;
        err_q   <= err_d;
    end

    // RAM array is never reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_word_q <= ram_q[idx];
            if (in_range && mem_req_data.we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_req_data.be[b]) ram_q[idx][8*b +: 8] <= mem_req_data.wdata[8*b +: 8];
            end
        end
    end

    assign s1_resp = '{rdata: (rd_ok_q ? rd_word_q : 32'h0), err: err_q};

    generate
        if (LATENCY == 1) begin : g_pipe1
            assign pipe_out = s1_resp;
        end else begin : g_pipe
            mem_resp_t dat_q [2:LATENCY];
            mem_resp_t dat_d [2:LATENCY];
            always_comb begin
                dat_d[2] = s1_resp;
                for (int k = 3; k <= LATENCY; k++) dat_d[k] = dat_q[k-1];
            end
            always_ff @(posedge clk) dat_q <= dat_d;
            assign pipe_out = dat_q[LATENCY];
        end
    endgenerate

    assign pipe_vld = vld_pipe_q[LATENCY];

    // An arriving result bypasses an empty FIFO; it is only buffered if not taken this cycle.
    assign fifo_push = pipe_vld && !fifo_full && !(fifo_empty && mem_resp_ready);
    assign fifo_pop  = !fifo_empty && mem_resp_ready;

    sync_fifo #(.T(mem_resp_t), .DEPTH(OUTSTANDING)) u_resp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (pipe_out),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign mem_resp_valid = pipe_vld || !fifo_empty;
    assign mem_resp_data  = !fifo_empty ? fifo_head : (pipe_vld ? pipe_out : '0);

endmodule
